// File: rtl/ctrl_pkg.sv
// Shared opcode, state and ALU-function encodings for the instruction sequencer.
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_t;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_NOOP   = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous clear, increment that wraps modulo 2**WIDTH.
module pc_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] pc
);

    // Clear has priority over increment; natural overflow gives the wrap.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer for the 16-bit datapath: owns PC and IR, fetches from
// a registered-address ROM and issues per-state Moore control outputs.
//
// state  | meaning
// INIT   | clear PC, start fetching
// FETCH  | latch IR from ROM, advance PC
// DECODE | pick execute state from IR[15:12]
// LOAD_A | RAM read in flight (covers read latency)
// LOAD_B | write RAM data into regfile
// STORE  | write regfile port A into RAM
// ADD    | regfile A + B into regfile
// SUB    | regfile A - B into regfile
// NOOP   | nothing, back to FETCH
// HALT   | frozen until reset
module control_unit
    import ctrl_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     instr_data,
    output logic [PC_W-1:0] pc_addr,
    output logic [15:0]     ir_out,
    output logic [3:0]      state_out,
    output logic            halted,
    output logic [7:0]      D_addr,
    output logic            D_wr,
    output logic            RF_sel,
    output logic            RF_W_en,
    output logic [3:0]      WriteAddr,
    output logic [3:0]      rdAddrA,
    output logic [3:0]      rdAddrB,
    output logic [2:0]      ALU_s0
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;

    pc_counter #(
        .WIDTH(PC_W)
    ) u_pc (
        .clk  (clk),
        .reset(reset),
        .clr  (state == S_INIT),
        .inc  (state == S_FETCH),
        .pc   (pc_addr)
    );

    // State and instruction registers; IR only loads in FETCH so HALT freezes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
            ir    <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                ir <= instr_data;
            end
        end
    end

    // Next-state selection and Moore control decode.
    always_comb begin
        state_nxt = state;
        D_wr      = 1'b0;
        RF_sel    = 1'b0;
        RF_W_en   = 1'b0;
        ALU_s0    = ALU_PASS;
        halted    = 1'b0;
        case (state)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (ir[15:12])
                    OP_STORE: state_nxt = S_STORE;
                    OP_LOAD:  state_nxt = S_LOAD_A;
                    OP_ADD:   state_nxt = S_ADD;
                    OP_SUB:   state_nxt = S_SUB;
                    OP_HALT:  state_nxt = S_HALT;
                    default:  state_nxt = S_NOOP;
                endcase
            end
            S_LOAD_A: begin
                RF_sel    = 1'b1;
                state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                RF_sel    = 1'b1;
                RF_W_en   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_STORE: begin
                D_wr      = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADD: begin
                ALU_s0    = ALU_ADD;
                RF_W_en   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_SUB: begin
                ALU_s0    = ALU_SUB;
                RF_W_en   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_NOOP:   state_nxt = S_FETCH;
            S_HALT: begin
                halted    = 1'b1;
                state_nxt = S_HALT;
            end
            default:  state_nxt = S_INIT;
        endcase
        // No datapath write may escape in the cycle a reset is being sampled.
        if (reset) begin
            D_wr    = 1'b0;
            RF_W_en = 1'b0;
        end
    end

    // Register-address fields are straight IR slices; the RAM address moves
    // to IR[11:4] only while a load is in progress.
    always_comb begin
        WriteAddr = ir[3:0];
        rdAddrA   = ir[11:8];
        rdAddrB   = ir[7:4];
        D_addr    = ((state == S_LOAD_A) || (state == S_LOAD_B)) ? ir[11:4] : ir[7:0];
    end

    assign ir_out    = ir;
    assign state_out = state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected records are queued
// as each program is set up and popped against the DUT one cycle at a time.
module tb_control_unit;

    localparam int PC_W = 7;

    typedef struct packed {
        logic [3:0]  st;
        logic [6:0]  pc;
        logic [15:0] ir;
        logic [7:0]  daddr;
        logic        dwr;
        logic        rfsel;
        logic        rfw;
        logic        halt;
        logic [2:0]  alu;
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [3:0]  rb;
    } rec_t;

    typedef struct {
        logic [47:0] nm;
        logic [15:0] instr;
        int          nexec;
        rec_t        ex0;
        rec_t        ex1;
    } vec_t;

    logic            clk;
    logic            reset;
    logic [15:0]     instr_data;
    logic [PC_W-1:0] pc_addr;
    logic [15:0]     ir_out;
    logic [3:0]      state_out;
    logic            halted;
    logic [7:0]      D_addr;
    logic            D_wr;
    logic            RF_sel;
    logic            RF_W_en;
    logic [3:0]      WriteAddr;
    logic [3:0]      rdAddrA;
    logic [3:0]      rdAddrB;
    logic [2:0]      ALU_s0;

    logic [15:0] rom [0:127];
    rec_t        q [$];
    vec_t        vecs [0:6];
    int          n_pass  = 0;
    int          n_total = 0;

    control_unit #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr_data(instr_data),
        .pc_addr   (pc_addr),
        .ir_out    (ir_out),
        .state_out (state_out),
        .halted    (halted),
        .D_addr    (D_addr),
        .D_wr      (D_wr),
        .RF_sel    (RF_sel),
        .RF_W_en   (RF_W_en),
        .WriteAddr (WriteAddr),
        .rdAddrA   (rdAddrA),
        .rdAddrB   (rdAddrB),
        .ALU_s0    (ALU_s0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM with registered address: one-cycle read latency.
    always @(posedge clk) instr_data <= rom[pc_addr];

    function automatic rec_t rec(input logic [3:0] st, input logic [6:0] pc,
                                 input logic [15:0] ir, input logic [7:0] daddr,
                                 input logic dwr, input logic rfsel, input logic rfw,
                                 input logic halt, input logic [2:0] alu);
        rec_t r;
        r.st = st; r.pc = pc; r.ir = ir; r.daddr = daddr;
        r.dwr = dwr; r.rfsel = rfsel; r.rfw = rfw; r.halt = halt; r.alu = alu;
        r.wa = ir[3:0]; r.ra = ir[11:8]; r.rb = ir[7:4];
        return r;
    endfunction

    function automatic rec_t snap();
        rec_t r;
        r.st = state_out; r.pc = pc_addr; r.ir = ir_out; r.daddr = D_addr;
        r.dwr = D_wr; r.rfsel = RF_sel; r.rfw = RF_W_en; r.halt = halted; r.alu = ALU_s0;
        r.wa = WriteAddr; r.ra = rdAddrA; r.rb = rdAddrB;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Pop one expected record per cycle and compare, then step to the next cycle.
    task automatic drain(input string name);
        rec_t e;
        rec_t a;
        int   cyc;
        cyc = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            a = snap();
            n_total++;
            if (a !== e) begin
                $display("FAIL %s cyc%0d: got st=%0h pc=%0h ir=%0h da=%0h dwr=%b sel=%b rfw=%b h=%b alu=%0h wa/ra/rb=%0h/%0h/%0h expected st=%0h pc=%0h ir=%0h da=%0h dwr=%b sel=%b rfw=%b h=%b alu=%0h wa/ra/rb=%0h/%0h/%0h",
                         name, cyc, a.st, a.pc, a.ir, a.daddr, a.dwr, a.rfsel, a.rfw, a.halt, a.alu, a.wa, a.ra, a.rb,
                         e.st, e.pc, e.ir, e.daddr, e.dwr, e.rfsel, e.rfw, e.halt, e.alu, e.wa, e.ra, e.rb);
            end else begin
                n_pass++;
            end
            cyc++;
            advance();
        end
    endtask

    // Leaves the bench #1 after the reset edge with reset released: cycle 0 (INIT).
    task automatic reset_dut();
        reset = 1'b1;
        advance();
        reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] instr;
        logic [15:0] prev;
        int          kk;

        reset = 1'b1;
        clear_rom();

        vecs[0] = '{"ADD",   16'h3123, 1, rec(4'd6, 7'd1, 16'h3123, 8'h23, 0, 0, 1, 0, 3'd1), '0};
        vecs[1] = '{"LOAD",  16'h2A57, 2, rec(4'd3, 7'd1, 16'h2A57, 8'hA5, 0, 1, 0, 0, 3'd0),
                                          rec(4'd4, 7'd1, 16'h2A57, 8'hA5, 0, 1, 1, 0, 3'd0)};
        vecs[2] = '{"STORE", 16'h1C3F, 1, rec(4'd5, 7'd1, 16'h1C3F, 8'h3F, 1, 0, 0, 0, 3'd0), '0};
        vecs[3] = '{"SUB",   16'h4321, 1, rec(4'd7, 7'd1, 16'h4321, 8'h21, 0, 0, 1, 0, 3'd2), '0};
        vecs[4] = '{"NOOP",  16'h0000, 1, rec(4'd8, 7'd1, 16'h0000, 8'h00, 0, 0, 0, 0, 3'd0), '0};
        vecs[5] = '{"OPF",   16'hF0AB, 1, rec(4'd8, 7'd1, 16'hF0AB, 8'hAB, 0, 0, 0, 0, 3'd0), '0};
        vecs[6] = '{"OP7",   16'h7E96, 1, rec(4'd8, 7'd1, 16'h7E96, 8'h96, 0, 0, 0, 0, 3'd0), '0};

        // Single-instruction programs from reset through the following FETCH.
        for (int v = 0; v < 7; v++) begin
            clear_rom();
            instr  = vecs[v].instr;
            rom[0] = instr;
            reset_dut();
            q.push_back(rec(4'd0, 7'd0, 16'h0000, 8'h00, 0, 0, 0, 0, 3'd0));
            q.push_back(rec(4'd1, 7'd0, 16'h0000, 8'h00, 0, 0, 0, 0, 3'd0));
            q.push_back(rec(4'd2, 7'd1, instr, instr[7:0], 0, 0, 0, 0, 3'd0));
            q.push_back(vecs[v].ex0);
            if (vecs[v].nexec == 2) q.push_back(vecs[v].ex1);
            q.push_back(rec(4'd1, 7'd1, instr, instr[7:0], 0, 0, 0, 0, 3'd0));
            q.push_back(rec(4'd2, 7'd2, 16'h0000, 8'h00, 0, 0, 0, 0, 3'd0));
            drain($sformatf("%0s", vecs[v].nm));
        end

        // HALT holds for 20 cycles with PC and IR frozen, then reset recovers.
        clear_rom();
        rom[0] = 16'h5000;
        rom[1] = 16'h3123;
        reset_dut();
        q.push_back(rec(4'd0, 7'd0, 16'h0000, 8'h00, 0, 0, 0, 0, 3'd0));
        q.push_back(rec(4'd1, 7'd0, 16'h0000, 8'h00, 0, 0, 0, 0, 3'd0));
        q.push_back(rec(4'd2, 7'd1, 16'h5000, 8'h00, 0, 0, 0, 0, 3'd0));
        for (int i = 0; i < 20; i++)
            q.push_back(rec(4'd9, 7'd1, 16'h5000, 8'h00, 0, 0, 0, 1, 3'd0));
        drain("HALT");
        reset = 1'b1;
        advance();
        reset = 1'b0;
        q.push_back(rec(4'd0, 7'd0, 16'h0000, 8'h00, 0, 0, 0, 0, 3'd0));
        q.push_back(rec(4'd1, 7'd0, 16'h0000, 8'h00, 0, 0, 0, 0, 3'd0));
        drain("HALT_RST");

        // Reset landing on the STORE cycle suppresses D_wr.
        clear_rom();
        rom[0] = 16'h1C3F;
        reset_dut();
        advance(); advance(); advance();
        chk("store_reached", {60'd0, state_out}, 64'd5);
        chk("store_dwr_live", {63'd0, D_wr}, 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_store_dwr", {63'd0, D_wr}, 64'd0);
        chk("rst_store_rfw", {63'd0, RF_W_en}, 64'd0);
        advance();
        reset = 1'b0;
        chk("rst_store_init", {60'd0, state_out}, 64'd0);
        chk("rst_store_pc", {57'd0, pc_addr}, 64'd0);

        // Reset landing on LOAD_B suppresses RF_W_en and abandons the load.
        rom[0] = 16'h2A57;
        reset_dut();
        advance(); advance(); advance(); advance();
        chk("loadb_reached", {60'd0, state_out}, 64'd4);
        reset = 1'b1;
        #1;
        chk("rst_loadb_rfw", {63'd0, RF_W_en}, 64'd0);
        chk("rst_loadb_dwr", {63'd0, D_wr}, 64'd0);
        advance();
        reset = 1'b0;
        chk("rst_loadb_init", {60'd0, state_out}, 64'd0);
        chk("rst_loadb_ir", {48'd0, ir_out}, 64'd0);

        // Fill the ROM with NOOP-class opcodes (0 and 6..F) and run past the PC wrap.
        for (int k = 0; k < 128; k++) begin
            instr       = {((k % 11) == 0) ? 4'd0 : 4'(6 + (k % 10)), 4'(k % 16), 8'(k)};
            rom[k]      = instr;
        end
        reset_dut();
        q.push_back(rec(4'd0, 7'd0, 16'h0000, 8'h00, 0, 0, 0, 0, 3'd0));
        prev = 16'h0000;
        for (int k = 0; k < 130; k++) begin
            kk    = k % 128;
            instr = rom[kk];
            q.push_back(rec(4'd1, 7'(kk), prev, prev[7:0], 0, 0, 0, 0, 3'd0));
            q.push_back(rec(4'd2, 7'((kk + 1) % 128), instr, instr[7:0], 0, 0, 0, 0, 3'd0));
            q.push_back(rec(4'd8, 7'((kk + 1) % 128), instr, instr[7:0], 0, 0, 0, 0, 3'd0));
            prev = instr;
        end
        drain("WRAP");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
